// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity types,
// legal oversampling ratios and the 2-of-3 vote helper.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StStart  = 3'd1;
  localparam state_t StData   = 3'd2;
  localparam state_t StParity = 3'd3;
  localparam state_t StStop   = 3'd4;
  localparam state_t StErrChk = 3'd5;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  localparam int unsigned PrescX8  = 8;
  localparam int unsigned PrescX16 = 16;
  localparam int unsigned PrescX32 = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Line, configuration and result signals of the UART receiver.
// master drives the line and configuration; slave is the receiver.
interface uart_rx_if #(
  parameter int unsigned width   = 8,
  parameter int unsigned PRESC_W = 6
);
  logic               RX_IN;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic [PRESC_W-1:0] Prescale;
  logic [width-1:0]   P_DATA;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample counter (0..presc-1, wrapping) and bit counter advanced on each wrap.
module uart_rx_edge_bit_cnt #(
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned BitCntW = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic [PRESC_W-1:0] edge_cnt_o,
  output logic [BitCntW-1:0] bit_cnt_o,
  output logic               wrap_o
);

  logic [PRESC_W-1:0] edge_cnt_q;
  logic [BitCntW-1:0] bit_cnt_q;

  // presc 0 wraps at the natural all-ones rollover, so a wrap always happens.
  assign wrap_o     = en_i && (edge_cnt_q == presc_i - PRESC_W'(1));
  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (clr_i) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else if (en_i) begin
      if (wrap_o) begin
        edge_cnt_q <= '0;
        bit_cnt_q  <= bit_cnt_q + BitCntW'(1);
      end else begin
        edge_cnt_q <= edge_cnt_q + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop deserialiser with error pulses.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 sampling around the bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned width   = 8,
  parameter int unsigned PRESC_W = 6
) (
  input  logic      CLK,
  input  logic      RST,
  uart_rx_if.slave  bus
);

  localparam int unsigned BitCntW = $clog2(width + 4);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q;
  logic               par_en_q, par_typ_q, par_mis_q;
  logic [width-1:0]   shift_q, p_data_q;
  logic               data_valid_q, par_err_q, stp_err_q;
  logic [PRESC_W-1:0] edge_cnt, half;
  logic [BitCntW-1:0] bit_cnt;
  logic               wrap, decide, bit_val;

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W),
    .BitCntW (BitCntW)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (state_q != StIdle),
    .clr_i      (state_q == StIdle),
    .presc_i    (presc_q),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .wrap_o     (wrap)
  );

  assign half   = presc_q >> 1;
  assign decide = (state_q != StIdle) && (edge_cnt == half + PRESC_W'(1));

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic samp_m1_q, samp_0_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_m1_q <= 1'b1;
      samp_0_q  <= 1'b1;
    end else begin
      if (edge_cnt == half - PRESC_W'(1)) samp_m1_q <= bus.RX_IN;
      if (edge_cnt == half)               samp_0_q  <= bus.RX_IN;
    end
  end

  assign bit_val = maj3(samp_m1_q, samp_0_q, bus.RX_IN);
`else
  logic samp_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_q <= 1'b1;
    end else if (edge_cnt == half) begin
      samp_q <= bus.RX_IN;
    end
  end

  assign bit_val = samp_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!bus.RX_IN) state_d = StStart;
      StStart: begin
        if (decide && bit_val) state_d = StIdle;
        else if (wrap)         state_d = StData;
      end
      StData:   if (wrap && bit_cnt == BitCntW'(width)) state_d = par_en_q ? StParity : StStop;
      StParity: if (wrap) state_d = StStop;
      // Leave on the decision cycle for half a bit of margin; wrap only hits on bad presc.
      StStop: begin
        if (decide)    state_d = StErrChk;
        else if (wrap) state_d = StIdle;
      end
      StErrChk: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= ParEven;
      par_mis_q    <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      if (state_q == StIdle && !bus.RX_IN) begin
        presc_q   <= bus.Prescale;
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        par_mis_q <= 1'b0;
      end
      if (state_q == StData && decide) shift_q <= {bit_val, shift_q[width-1:1]};
      if (state_q == StParity && decide) par_mis_q <= bit_val != ((^shift_q) ^ par_typ_q);
      // Flags register on the stop decision so they show during the ErrChk cycle.
      if (state_q == StStop && decide) begin
        stp_err_q    <= !bit_val;
        par_err_q    <= bit_val && par_mis_q;
        data_valid_q <= bit_val && !par_mis_q;
        if (bit_val && !par_mis_q) p_data_q <= shift_q;
      end
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events, a monitor pops them.
module tb_uart_rx;

  localparam int KValid = 0;
  localparam int KPar   = 1;
  localparam int KStop  = 2;
  localparam int KNone  = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  ev_t  sb[$];
  ev_t  ev;
  int   act_kind;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] model_pdata = 8'h00;

  uart_rx_if #(.width(8), .PRESC_W(6)) bus ();

  uart_rx #(.width(8), .PRESC_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int p);
    bus.RX_IN = b;
    tick(p);
  endtask

  task automatic push(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                            input bit bad_par, input bit stop_v, input int gap);
    logic pb;
    bus.Prescale = p[5:0];
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) begin
      pb = (^d) ^ ptyp ^ bad_par;
      drive_bit(pb, p);
    end
    drive_bit(stop_v, p);
    bus.RX_IN = 1'b1;
    if (gap > 0) tick(gap);
  endtask

  always @(negedge CLK) begin
    if (!RST && (bus.data_valid || bus.par_err || bus.stp_err)) begin
      act_kind = bus.data_valid ? KValid : (bus.par_err ? KPar : KStop);
      check("flags_onehot", 32'($countones({bus.data_valid, bus.par_err, bus.stp_err})), 1);
      if (sb.size() == 0) begin
        check("unexpected_event", act_kind, KNone);
      end else begin
        ev = sb.pop_front();
        check("event_kind", act_kind, ev.kind);
        check("p_data", 32'(bus.P_DATA), 32'(ev.data));
      end
    end
  end

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.Prescale = 6'd8;
    tick(3);
    check("rst_p_data", 32'(bus.P_DATA), 0);
    check("rst_data_valid", 32'(bus.data_valid), 0);
    check("rst_par_err", 32'(bus.par_err), 0);
    check("rst_stp_err", 32'(bus.stp_err), 0);
    RST = 1'b0;
    tick(4);

    // 1: good frame with even parity
    model_pdata = 8'hA5;
    push(KValid, model_pdata);
    send_frame(8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 24);

    // 2: odd parity, wrong parity bit
    push(KPar, model_pdata);
    send_frame(16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 48);

    // 3: stop bit low
    push(KStop, model_pdata);
    send_frame(8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 32);

    // 4: two-cycle false start
    bus.Prescale = 6'd16;
    bus.RX_IN = 1'b0;
    tick(2);
    bus.RX_IN = 1'b1;
    tick(64);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Single-cycle glitch landing on the centre sample of every data bit
    model_pdata = 8'h3C;
    push(KValid, model_pdata);
    bus.Prescale = 6'd16;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      bus.RX_IN = model_pdata[i];
      tick(9);
      bus.RX_IN = ~model_pdata[i];
      tick(1);
      bus.RX_IN = model_pdata[i];
      tick(6);
    end
    drive_bit(1'b1, 16);
    tick(48);
`endif

    // 5: back-to-back frames at x32
    push(KValid, 8'h01);
    push(KValid, 8'h80);
    model_pdata = 8'h80;
    send_frame(32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 0);
    send_frame(32, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 96);

    // 6: reset mid-DATA, then resend
    bus.Prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 4);
    RST = 1'b1;
    tick(2);
    check("midrst_p_data", 32'(bus.P_DATA), 0);
    check("midrst_data_valid", 32'(bus.data_valid), 0);
    check("midrst_par_err", 32'(bus.par_err), 0);
    check("midrst_stp_err", 32'(bus.stp_err), 0);
    bus.RX_IN = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(16);
    model_pdata = 8'h55;
    push(KValid, model_pdata);
    send_frame(8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 64);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
